// File: rtl/tis100_stream_src.sv
// ROM-backed input stream for the tis100 grid: offers each stored word, saturated to
// [-999,+999], on a node's input port using the four-phase valid/ack port handshake.
module tis100_stream_src #(
    parameter int   DEPTH    = 39,
    parameter int   ADDR_W   = 6,
    parameter bit   LOOP     = 1'b0,
    // Packed ROM image, word i at bits [16*i +: 16], 16-bit two's complement.
    parameter logic [16*((DEPTH > 0) ? DEPTH : 1)-1:0] ROM_INIT = '0
) (
    input  logic              clk,
    input  logic              resetN,
    input  logic              enable,
    output logic [14:0]       portOut,
    input  logic [14:0]       portIn,
    output logic [ADDR_W-1:0] index,
    output logic [10:0]       lastValue,
    output logic              done,
    output logic [1:0]        state_dbg
);
    localparam int ROM_D = (DEPTH > 0) ? DEPTH : 1;
    localparam logic [ADDR_W-1:0] END_IDX  = ADDR_W'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    // Handshake: valid (portOut[11]) rises only from IDLE/RELEASE with enable high and
    // is held with stable data until an edge with ack (portIn[12]) high; the source then
    // drops valid and waits for ack to fall before the next offer.
    typedef enum logic [1:0] {IDLE, SEND, RELEASE, DONE} state_t;

    state_t      state, state_next;
    logic [10:0] data_q;
    logic [15:0] rom_word;
    logic [10:0] sat_word;
    logic [ADDR_W-1:0] index_inc;
    logic        ack;
    logic        at_end;
    logic        unused_port_bits;

    assign ack              = portIn[12];
    assign unused_port_bits = ^{portIn[14:13], portIn[11:0]};
    assign at_end           = !LOOP && (index == END_IDX);
    assign index_inc        = (LOOP && index == LAST_IDX) ? '0 : index + ADDR_W'(1);

    always_comb begin
        rom_word = '0;
        for (int i = 0; i < ROM_D; i++) begin
            if (index == ADDR_W'(i)) rom_word = ROM_INIT[16*i +: 16];
        end
    end

    always_comb begin
        if ($signed(rom_word) > 16'sd999)       sat_word = 11'h3E7;
        else if ($signed(rom_word) < -16'sd999) sat_word = 11'h419;
        else                                    sat_word = rom_word[10:0];
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (at_end)      state_next = DONE;
                else if (enable) state_next = SEND;
            end
            SEND: begin
                if (ack) state_next = RELEASE;
            end
            RELEASE: begin
                if (!ack) begin
                    if (at_end)      state_next = DONE;
                    else if (enable) state_next = SEND;
                    else             state_next = IDLE;
                end
            end
            DONE:    state_next = DONE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state     <= IDLE;
            data_q    <= '0;
            index     <= '0;
            lastValue <= '0;
        end else begin
            state <= state_next;
            // Latch the word once on offer entry so it stays stable under backpressure.
            if (state_next == SEND && state != SEND) data_q <= sat_word;
            if (state == SEND && ack) begin
                lastValue <= data_q;
                index     <= index_inc;
            end
        end
    end

    assign portOut   = {3'b000, (state == SEND), (state == SEND) ? data_q : 11'd0};
    assign done      = (state == DONE);
    assign state_dbg = state;
endmodule
